// File: rtl/dmem_pkg.sv
// dmem_pkg: shared sizes, FSM encoding and lane masks for the data-memory access controller.
// The misaligned() helper is used only when DMEM_ALIGN_CHECK_EN is defined.
package dmem_pkg;
    localparam int DATA_W = 32;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACCESS = 2'b01,
        S_WAIT   = 2'b10,
        S_RESP   = 2'b11
    } state_t;

    localparam logic [3:0] LANE_B0  = 4'b0001;
    localparam logic [3:0] LANE_HLO = 4'b0011;
    localparam logic [3:0] LANE_HHI = 4'b1100;
    localparam logic [3:0] LANE_ALL = 4'b1111;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == SIZE_HALF && off[0]) || (size == SIZE_WORD && off != 2'b00);
    endfunction
endpackage

// File: rtl/dmem_if.sv
// dmem_if: request/response and RAM-side signals of the data-memory access controller.
interface dmem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              stall;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_dout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, stall, ram_en, ram_we, ram_addr, ram_din
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_dout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall, ram_en, ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane strobes/replication for stores and extract/extend for loads.
module dmem_lane_align import dmem_pkg::*; (
    input  logic [1:0]        size,
    input  logic [1:0]        off,
    input  logic              uns,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] dout,
    output logic [3:0]        we,
    output logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] rdata
);
    logic [7:0]  b;
    logic [15:0] h;

    // Stores replicate the datum across lanes; loads pick the addressed field and extend it.
    always_comb begin
        b     = dout[8*off +: 8];
        h     = dout[16*off[1] +: 16];
        we    = size == SIZE_BYTE ? LANE_B0 << off :
                size == SIZE_HALF ? (off[1] ? LANE_HHI : LANE_HLO) :
                size == SIZE_WORD ? LANE_ALL : 4'b0000;
        din   = size == SIZE_BYTE ? {4{wdata[7:0]}} :
                size == SIZE_HALF ? {2{wdata[15:0]}} : wdata;
        rdata = size == SIZE_BYTE ? {{24{b[7] & ~uns}}, b} :
                size == SIZE_HALF ? {{16{h[15] & ~uns}}, h} : dout;
    end
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage load/store controller in front of a synchronous data RAM.
// rst is asynchronous active-low. Define DMEM_ALIGN_CHECK_EN to reject misaligned half/word accesses.
module dmem_access_ctrl import dmem_pkg::*; #(
    parameter int ADDR_W  = 32,
    parameter int RAM_LAT = 1
) (
    input logic     clk,
    input logic     rst,
    dmem_if.slave   bus
);
    state_t            state_q, state_d;
    logic              we_q, we_d, uns_q, uns_d, err_q, err_d;
    logic [1:0]        size_q, size_d, off_q, off_d, cnt_q, cnt_d;
    logic              ready_q, ready_d, stall_q, stall_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, ram_en_q, ram_en_d;
    logic [DATA_W-1:0] rdata_q, rdata_d, ram_din_q, ram_din_d;
    logic [3:0]        ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              req_bad, accept;
    logic [1:0]        al_size, al_off;
    logic [3:0]        al_we;
    logic [DATA_W-1:0] al_din, al_rdata;

    // A request that can never touch the RAM is diverted straight to the error response.
    always_comb begin
`ifdef DMEM_ALIGN_CHECK_EN
        req_bad = bus.req_size == SIZE_ILL || misaligned(bus.req_size, bus.req_addr[1:0]);
`else
        req_bad = bus.req_size == SIZE_ILL;
`endif
    end

    assign accept  = state_q == S_IDLE && bus.req_valid;
    assign al_size = state_q == S_IDLE ? bus.req_size : size_q;
    assign al_off  = state_q == S_IDLE ? bus.req_addr[1:0] : off_q;

    dmem_lane_align u_align (
        .size  (al_size),
        .off   (al_off),
        .uns   (uns_q),
        .wdata (bus.req_wdata),
        .dout  (bus.ram_dout),
        .we    (al_we),
        .din   (al_din),
        .rdata (al_rdata)
    );

    // Next state, request latch and RAM latency counter.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        uns_d   = uns_q;
        err_d   = err_q;
        size_d  = size_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (bus.req_valid) begin
                we_d    = bus.req_we;
                uns_d   = bus.req_unsigned;
                err_d   = req_bad;
                size_d  = bus.req_size;
                off_d   = bus.req_addr[1:0];
                state_d = req_bad ? S_RESP : S_ACCESS;
            end
            S_ACCESS: begin
                state_d = we_q ? S_RESP : S_WAIT;
                cnt_d   = 2'(RAM_LAT - 1);
            end
            S_WAIT: begin
                state_d = cnt_q == 2'd0 ? S_RESP : S_WAIT;
                cnt_d   = cnt_q - 2'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Port values are computed from the next state so every output comes straight from a flop.
    always_comb begin
        ready_d     = state_d == S_IDLE;
        stall_d     = state_d != S_IDLE;
        ram_en_d    = state_d == S_ACCESS;
        ram_we_d    = accept && !req_bad && bus.req_we ? al_we : 4'b0000;
        ram_addr_d  = accept && !req_bad ? {bus.req_addr[ADDR_W-1:2], 2'b00} : ram_addr_q;
        ram_din_d   = accept && !req_bad && bus.req_we ? al_din : ram_din_q;
        rsp_valid_d = state_d == S_RESP;
        rsp_err_d   = state_d == S_RESP && err_d;
        rdata_d     = state_q == S_WAIT && state_d == S_RESP ? al_rdata : '0;
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            err_q       <= 1'b0;
            size_q      <= SIZE_BYTE;
            off_q       <= 2'b00;
            cnt_q       <= 2'b00;
            ready_q     <= 1'b1;
            stall_q     <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 4'b0000;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            uns_q       <= uns_d;
            err_q       <= err_d;
            size_q      <= size_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            stall_q     <= stall_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.stall     = stall_q;
    assign bus.ram_en    = ram_en_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_din   = ram_din_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rdata_q;
endmodule
